// File: rtl/latch_pipe_hs.sv
// Inter-stage latch carrying {instr, instr_set, pc} with valid/ready and sync flush.
// Define LATCH_SKID_EN for a 2-entry skid buffer with a registered in_ready.
`ifndef ISET_BASE
`define ISET_BASE '0
`endif

module latch_pipe_hs #(
  parameter int INSTR_W = 12,
  parameter int ISET_W = 4,
  parameter int PC_W = 12,
  parameter logic [ISET_W-1:0] ISET_RST = `ISET_BASE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ISET_W-1:0]  instr_set_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ISET_W-1:0]  instr_set_out,
  output logic [PC_W-1:0]    pc_out
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ISET_W-1:0]  iset;
    logic [PC_W-1:0]    pc;
  } beat_t;

  localparam beat_t BEAT_RST = '{
    instr: '0,
    iset: ISET_RST,
    pc: '0
  };

  beat_t in_beat;
  beat_t main_q;
  beat_t main_d;
  logic  main_valid;
  logic  main_valid_d;
  logic  accept;
  logic  fire;

  assign in_beat = '{
    instr: instr_in,
    iset: instr_set_in,
    pc: pc_in
  };

  assign accept = in_valid & in_ready;
  assign fire = main_valid & out_ready;

  assign out_valid = main_valid;
  assign instr_out = main_q.instr;
  assign instr_set_out = main_q.iset;
  assign pc_out = main_q.pc;

`ifdef LATCH_SKID_EN
  beat_t skid_q;
  beat_t skid_d;
  logic  skid_valid;
  logic  skid_valid_d;

  // Registered ready: only a full skid entry blocks upstream.
  assign in_ready = !skid_valid;

  always_comb begin
    main_d = main_q;
    main_valid_d = main_valid;
    skid_d = skid_q;
    skid_valid_d = skid_valid;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid) begin
      if (fire) begin
        main_d = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || fire) begin
        main_d = in_beat;
        main_valid_d = 1'b1;
      end else begin
        skid_d = in_beat;
        skid_valid_d = 1'b1;
      end
    end else if (fire) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
      skid_valid <= 1'b0;
    end else begin
      skid_q <= skid_d;
      skid_valid <= skid_valid_d;
    end
  end
`else
  assign in_ready = !main_valid | out_ready;

  always_comb begin
    main_d = main_q;
    main_valid_d = main_valid;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_d = in_beat;
      main_valid_d = 1'b1;
    end else if (fire) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= BEAT_RST;
      main_valid <= 1'b0;
    end else begin
      main_q <= main_d;
      main_valid <= main_valid_d;
    end
  end

endmodule

// File: tb/tb_latch_pipe_hs.sv
// Directed and random checks of latch_pipe_hs in either build.
// Payload fields are derived from pc so the scoreboard sees whole beats.
module tb_latch_pipe_hs;

`ifdef LATCH_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [3:0] IRST = 4'hA;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] instr_in;
  logic [3:0]  instr_set_in;
  logic [11:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] instr_out;
  logic [3:0]  instr_set_out;
  logic [11:0] pc_out;

  int vectors = 0;
  int miscompares = 0;
  logic [27:0] q[$];

  latch_pipe_hs #(
    .INSTR_W(12),
    .ISET_W(4),
    .PC_W(12),
    .ISET_RST(IRST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr_in(instr_in),
    .instr_set_in(instr_set_in),
    .pc_in(pc_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .instr_out(instr_out),
    .instr_set_out(instr_set_out),
    .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [11:0] p);
    pc_in = p;
    instr_in = (p * 12'd7) ^ 12'h5a3;
    instr_set_in = p[3:0] ^ p[7:4] ^ 4'h3;
  endtask

  // Scoreboard: every presented beat must be the oldest accepted one.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid) begin
        vectors++;
        assert ((q.size() != 0) === 1'b1) else begin
          miscompares++;
          $error("FAIL sb_spurious: got out_valid=1 expected no beat pending");
        end
        if (q.size() != 0) begin
          vectors++;
          assert ({instr_out, instr_set_out, pc_out} === q[0]) else begin
            miscompares++;
            $error("FAIL sb_order: got %h expected %h",
                   {instr_out, instr_set_out, pc_out}, q[0]);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready)
        q.push_back({instr_in, instr_set_in, pc_in});
    end
  end

  initial begin
    logic [11:0] hpc;
    logic [11:0] hinstr;
    logic [3:0]  hiset;
    int unsigned nid;
    bit hold;

    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    beat(12'h0);
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_instr", 32'(instr_out), 32'h0);
    chk("rst_iset", 32'(instr_set_out), 32'(IRST));
    chk("rst_pc", 32'(pc_out), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 32'h1);

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      beat(12'(i));
      #1;
      chk("str_ready", 32'(in_ready), 32'h1);
      tick();
      chk("str_valid", 32'(out_valid), 32'h1);
      chk("str_pc", 32'(pc_out), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("str_end_valid", 32'(out_valid), 32'h0);
    chk("str_end_hold", 32'(pc_out), 32'h8);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    beat(12'h010);
    #1;
    chk("bp_ready0", 32'(in_ready), 32'h1);
    tick();
    chk("bp_pc0", 32'(pc_out), 32'h010);
    chk("bp_ready1", 32'(in_ready), 32'(SKID));
    beat(12'h011);
    tick();
    chk("bp_ready2", 32'(in_ready), 32'h0);
    chk("bp_pc1", 32'(pc_out), 32'h010);
    if (SKID) in_valid = 1'b0;
    tick();
    chk("bp_ready3", 32'(in_ready), 32'h0);
    chk("bp_pc2", 32'(pc_out), 32'h010);
    chk("bp_valid2", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(in_ready), 32'(!SKID));
    tick();
    in_valid = 1'b0;
    chk("bp_rel_pc", 32'(pc_out), 32'h011);
    chk("bp_rel_valid", 32'(out_valid), 32'h1);
    chk("bp_rel_ready2", 32'(in_ready), 32'h1);
    tick();
    chk("bp_drained", 32'(out_valid), 32'h0);

    // Flush with held entries
    out_ready = 1'b0;
    in_valid = 1'b1;
    beat(12'h012);
    tick();
    beat(12'h013);
    tick();
    flush = 1'b1;
    beat(12'h020);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'h0);
    chk("fl_ready", 32'(in_ready), 32'h1);
    chk("fl_payload_kept", 32'(pc_out), 32'h012);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_emit", 32'(out_valid), 32'h0);
    end

    // Hold under backpressure with toggling inputs
    out_ready = 1'b0;
    in_valid = 1'b1;
    beat(12'h030);
    tick();
    hpc = pc_out;
    hinstr = instr_out;
    hiset = instr_set_out;
    chk("hold_pc0", 32'(hpc), 32'h030);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      beat(12'h0c0 + 12'(i * 37));
      tick();
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_pc", 32'(pc_out), 32'(hpc));
      chk("hold_instr", 32'(instr_out), 32'(hinstr));
      chk("hold_iset", 32'(instr_set_out), 32'(hiset));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("hold_drained", 32'(out_valid), 32'h0);

    // Async reset mid-transfer with entries held
    out_ready = 1'b0;
    in_valid = 1'b1;
    beat(12'h040);
    tick();
    beat(12'h041);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_instr", 32'(instr_out), 32'h0);
    chk("arst_pc", 32'(pc_out), 32'h0);
    chk("arst_iset", 32'(instr_set_out), 32'(IRST));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("arst_ready", 32'(in_ready), 32'h1);
    tick();
    chk("arst_skid_gone", 32'(out_valid), 32'h0);

    // Random valid/ready with a legal upstream
    nid = 32'h100;
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 99) < 60);
        if (in_valid) begin
          beat(nid[11:0]);
          nid++;
        end
      end
      out_ready = ($urandom_range(0, 99) < 60);
      flush = ($urandom_range(0, 99) < 2);
      @(negedge clk);
      hold = in_valid && !in_ready && !flush;
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("rnd_valid_end", 32'(out_valid), 32'h0);
    chk("rnd_sb_empty", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
